// File: rtl/pwm_analyzer_multi_pkg.sv
// Shared types, defaults and elaboration helpers for the multi-channel PWM
// pulse-width analyser.
package pwm_analyzer_multi_pkg;

  localparam int unsigned DEF_CHANNELS           = 4;
  localparam int unsigned DEF_MAX_COUNTER_VALUE  = 2000;
  localparam int unsigned DEF_HIGH_COUNTER_VALUE = 1750;
  localparam int unsigned DEF_LOW_COUNTER_VALUE  = 1250;
  localparam int unsigned DEF_MAX_PERIOD_VALUE   = 40000;
  localparam int unsigned DEF_SYNC_STAGES        = 2;

  // Measurement phase of a channel: ACTIVE once a rise has been seen while
  // enabled, so the matching fall may publish a width.
  typedef enum logic {
    ARM_IDLE   = 1'b0,
    ARM_ACTIVE = 1'b1
  } arm_e;

  // Bits needed to hold values 0..max_value.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    return $clog2(max_value + 1);
  endfunction

  // Legal parameter ordering for the analyser.
  function automatic bit params_ok(input int unsigned low_value,
                                   input int unsigned high_value,
                                   input int unsigned max_counter,
                                   input int unsigned max_period,
                                   input int unsigned sync_stages);
    return (low_value <= high_value) && (high_value < max_counter) &&
           (max_counter < max_period) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/pwm_analyzer_multi_if.sv
// Control/status bundle of the PWM analyser.
//   enable_i  : global measurement enable
//   pwm_i     : asynchronous PWM inputs, bit c = channel c
//   state_o   : hysteresis output per channel
//   valid_o   : one-cycle pulse when a new width is latched
//   timeout_o : high while the channel is in timeout
//   t_on_o    : latched widths, channel c at [c*CW +: CW]
interface pwm_analyzer_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CW       = 11
);
  logic                     enable_i;
  logic [CHANNELS-1:0]      pwm_i;
  logic [CHANNELS-1:0]      state_o;
  logic [CHANNELS-1:0]      valid_o;
  logic [CHANNELS-1:0]      timeout_o;
  logic [CHANNELS*CW-1:0]   t_on_o;

  modport master (output enable_i, pwm_i,
                  input  state_o, valid_o, timeout_o, t_on_o);
  modport slave  (input  enable_i, pwm_i,
                  output state_o, valid_o, timeout_o, t_on_o);
endinterface

// File: rtl/pwm_analyzer_multi_channel.sv
// One PWM channel: input synchroniser, edge detect, high-time counter,
// period watchdog, armed tracking and hysteresis output.
//   clock_i, reset_i : clock, async active-low reset
//   enable_i         : measurement enable
//   pwm_i            : asynchronous PWM input
//   state_o, valid_o, timeout_o, t_on_o : registered channel results
module pwm_analyzer_multi_channel
  import pwm_analyzer_multi_pkg::*;
#(
  parameter int unsigned MAX_COUNTER_VALUE  = DEF_MAX_COUNTER_VALUE,
  parameter int unsigned HIGH_COUNTER_VALUE = DEF_HIGH_COUNTER_VALUE,
  parameter int unsigned LOW_COUNTER_VALUE  = DEF_LOW_COUNTER_VALUE,
  parameter int unsigned MAX_PERIOD_VALUE   = DEF_MAX_PERIOD_VALUE,
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  localparam int unsigned CW = cnt_width(MAX_COUNTER_VALUE),
  localparam int unsigned PW = cnt_width(MAX_PERIOD_VALUE)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          enable_i,
  input  logic          pwm_i,
  output logic          state_o,
  output logic          valid_o,
  output logic          timeout_o,
  output logic [CW-1:0] t_on_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;
  logic                   s_cur;
  logic                   rise;
  logic                   fall;

  arm_e                   arm_q;
  arm_e                   arm_d;
  logic [CW-1:0]          on_cnt;
  logic [CW-1:0]          on_cnt_d;
  logic [PW-1:0]          per_cnt;
  logic [PW-1:0]          per_cnt_d;
  logic                   state_d;
  logic                   valid_d;
  logic                   timeout_d;
  logic [CW-1:0]          t_on_d;

  assign s_cur = sync_q[SYNC_STAGES-1];
  assign rise  = s_cur & ~s_prev;
  assign fall  = ~s_cur & s_prev;

  // Synchroniser and edge-detect history; free-running regardless of enable.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_prev <= s_cur;
    end
  end

  // Armed state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      arm_q <= ARM_IDLE;
    end else begin
      arm_q <= arm_d;
    end
  end

  // Next-state for armed, counters and published results.
  always_comb begin
    arm_d     = arm_q;
    on_cnt_d  = on_cnt;
    per_cnt_d = per_cnt;
    state_d   = state_o;
    valid_d   = 1'b0;
    timeout_d = timeout_o;
    t_on_d    = t_on_o;

    if (!enable_i) begin
      arm_d     = ARM_IDLE;
      on_cnt_d  = '0;
      per_cnt_d = '0;
    end else if (rise) begin
      // A rise always wins over a watchdog expiry in the same cycle.
      arm_d     = ARM_ACTIVE;
      on_cnt_d  = CW'(1);
      per_cnt_d = PW'(1);
      timeout_d = 1'b0;
    end else begin
      if (s_cur && (on_cnt != CW'(MAX_COUNTER_VALUE))) begin
        on_cnt_d = on_cnt + CW'(1);
      end
      // Falls without a preceding armed rise are partial pulses; drop them.
      if (fall && (arm_q == ARM_ACTIVE)) begin
        t_on_d  = on_cnt;
        valid_d = 1'b1;
        arm_d   = ARM_IDLE;
        if (on_cnt > CW'(HIGH_COUNTER_VALUE)) begin
          state_d = 1'b1;
        end else if (on_cnt < CW'(LOW_COUNTER_VALUE)) begin
          state_d = 1'b0;
        end
      end
      if (per_cnt != PW'(MAX_PERIOD_VALUE)) begin
        per_cnt_d = per_cnt + PW'(1);
      end
      // Watchdog expiry forces the fail-safe output low; t_on is kept.
      if (per_cnt_d == PW'(MAX_PERIOD_VALUE)) begin
        timeout_d = 1'b1;
        state_d   = 1'b0;
        arm_d     = ARM_IDLE;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      on_cnt    <= '0;
      per_cnt   <= '0;
      state_o   <= 1'b0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      t_on_o    <= '0;
    end else begin
      on_cnt    <= on_cnt_d;
      per_cnt   <= per_cnt_d;
      state_o   <= state_d;
      valid_o   <= valid_d;
      timeout_o <= timeout_d;
      t_on_o    <= t_on_d;
    end
  end

endmodule

// File: rtl/pwm_analyzer_multi.sv
// Multi-channel PWM pulse-width analyser: CHANNELS independent channel
// instances with outputs packed onto the shared bundle.
//   clock_i : clock, all logic on rising edge
//   reset_i : asynchronous active-low reset
//   bus     : enable/pwm inputs and state/valid/timeout/t_on outputs
module pwm_analyzer_multi
  import pwm_analyzer_multi_pkg::*;
#(
  parameter int unsigned CHANNELS           = DEF_CHANNELS,
  parameter int unsigned MAX_COUNTER_VALUE  = DEF_MAX_COUNTER_VALUE,
  parameter int unsigned HIGH_COUNTER_VALUE = DEF_HIGH_COUNTER_VALUE,
  parameter int unsigned LOW_COUNTER_VALUE  = DEF_LOW_COUNTER_VALUE,
  parameter int unsigned MAX_PERIOD_VALUE   = DEF_MAX_PERIOD_VALUE,
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  pwm_analyzer_multi_if.slave   bus
);

  localparam int unsigned CW = cnt_width(MAX_COUNTER_VALUE);

  // Reject inconsistent threshold/period ordering at elaboration.
  if (!params_ok(LOW_COUNTER_VALUE, HIGH_COUNTER_VALUE, MAX_COUNTER_VALUE,
                 MAX_PERIOD_VALUE, SYNC_STAGES)) begin : g_param_check
    $error("pwm_analyzer_multi: need LOW <= HIGH < MAX_COUNTER < MAX_PERIOD and SYNC_STAGES >= 2");
  end

  logic [CHANNELS-1:0]    state_w;
  logic [CHANNELS-1:0]    valid_w;
  logic [CHANNELS-1:0]    timeout_w;
  logic [CHANNELS*CW-1:0] t_on_w;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pwm_analyzer_multi_channel #(
      .MAX_COUNTER_VALUE  (MAX_COUNTER_VALUE),
      .HIGH_COUNTER_VALUE (HIGH_COUNTER_VALUE),
      .LOW_COUNTER_VALUE  (LOW_COUNTER_VALUE),
      .MAX_PERIOD_VALUE   (MAX_PERIOD_VALUE),
      .SYNC_STAGES        (SYNC_STAGES)
    ) u_channel (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .enable_i  (bus.enable_i),
      .pwm_i     (bus.pwm_i[c]),
      .state_o   (state_w[c]),
      .valid_o   (valid_w[c]),
      .timeout_o (timeout_w[c]),
      .t_on_o    (t_on_w[c*CW +: CW])
    );
  end

  assign bus.state_o   = state_w;
  assign bus.valid_o   = valid_w;
  assign bus.timeout_o = timeout_w;
  assign bus.t_on_o    = t_on_w;

endmodule

// File: tb/tb_pwm_analyzer_multi.sv
// Randomised scoreboard bench for pwm_analyzer_multi (scaled-down thresholds).
module tb_pwm_analyzer_multi;
  import pwm_analyzer_multi_pkg::*;

  localparam int CH   = 4;
  localparam int MAXC = 200;
  localparam int HIGH = 175;
  localparam int LOW  = 125;
  localparam int MAXP = 600;
  localparam int SYNC = 2;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int HW   = SYNC + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_analyzer_multi_if #(.CHANNELS(CH), .CW(CW)) bus ();

  pwm_analyzer_multi #(
    .CHANNELS           (CH),
    .MAX_COUNTER_VALUE  (MAXC),
    .HIGH_COUNTER_VALUE (HIGH),
    .LOW_COUNTER_VALUE  (LOW),
    .MAX_PERIOD_VALUE   (MAXP),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int c, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s ch%0d: got %0d, expected %0d (edge %0d)", name, c, act, exp_v, cyc);
  endtask

  // ---------------- reference model ----------------
  // Works on edge indices: a pin change sampled at edge n is seen by the
  // channel at edge n+SYNC; width = fall sample edge - rise sample edge.
  typedef struct {int edge_n; int ton; bit st;} exp_t;
  exp_t            sb [CH][$];
  logic [HW-1:0]   hist [CH];
  bit              armed [CH];
  int              rise_e [CH];
  int              ref_e [CH];
  bit              exp_state [CH];
  bit              exp_to [CH];
  int              exp_ton [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        hist[c] = '0; armed[c] = 0; exp_state[c] = 0; exp_to[c] = 0;
        exp_ton[c] = 0; ref_e[c] = cyc + 1; sb[c].delete();
      end
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        bit d_cur, d_prev, fire;
        int w;
        hist[c] = {hist[c][HW-2:0], bus.pwm_i[c]};
        d_cur  = hist[c][SYNC];
        d_prev = hist[c][SYNC+1];
        fire   = 0;
        w      = 0;
        if (!bus.enable_i) begin
          armed[c] = 0;
          ref_e[c] = cyc + 1;
        end else if (d_cur && !d_prev) begin
          armed[c] = 1; rise_e[c] = cyc; ref_e[c] = cyc; exp_to[c] = 0;
        end else begin
          if (!d_cur && d_prev && armed[c]) begin
            w = cyc - rise_e[c];
            if (w > MAXC) w = MAXC;
            exp_ton[c] = w;
            if (w > HIGH) exp_state[c] = 1;
            else if (w < LOW) exp_state[c] = 0;
            armed[c] = 0;
            fire = 1;
          end
          // MAXP enabled cycles counted from the rise (or first enabled edge).
          if (cyc - ref_e[c] + 1 >= MAXP) begin
            exp_to[c] = 1; exp_state[c] = 0; armed[c] = 0;
          end
          if (fire) sb[c].push_back('{cyc, w, exp_state[c]});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < CH; c++) begin
        chk("state", c, int'(bus.state_o[c]), int'(exp_state[c]));
        chk("timeout", c, int'(bus.timeout_o[c]), int'(exp_to[c]));
        chk("t_on", c, int'(bus.t_on_o[c*CW +: CW]), exp_ton[c]);
        if (sb[c].size() == 0) begin
          if (bus.valid_o[c]) chk("unexpected_valid", c, int'(bus.valid_o[c]), 0);
        end else if (sb[c][0].edge_n == cyc) begin
          exp_t e;
          e = sb[c].pop_front();
          chk("valid", c, int'(bus.valid_o[c]), 1);
          chk("valid_t_on", c, int'(bus.t_on_o[c*CW +: CW]), e.ton);
          chk("valid_state", c, int'(bus.state_o[c]), int'(e.st));
        end else if (bus.valid_o[c]) begin
          chk("valid_edge", c, cyc, sb[c][0].edge_n);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {bit lvl; int len;} seg_t;
  seg_t seg_q [CH][$];
  int   rem [CH];
  bit   cur [CH];

  task automatic add_pulse(input int c, input int hi, input int lo);
    seg_q[c].push_back('{1'b1, hi});
    seg_q[c].push_back('{1'b0, lo});
  endtask

  task automatic step();
    logic [CH-1:0] v;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      if (rem[c] == 0) begin
        if (seg_q[c].size() > 0) begin
          seg_t s;
          s = seg_q[c].pop_front();
          cur[c] = s.lvl;
          rem[c] = s.len;
        end else begin
          cur[c] = 1'b0;
        end
      end
      if (rem[c] > 0) rem[c]--;
      v[c] = cur[c];
    end
    bus.pwm_i = v;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic bit busy();
    for (int c = 0; c < CH; c++)
      if (rem[c] > 0 || seg_q[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_idle(input int limit);
    int n = 0;
    while (busy() && n < limit) begin step(); n++; end
    chk("drain_in_budget", 0, int'(busy()), 0);
    run(SYNC + 4);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2 rst_n = 1'b0;
    run(n);
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CH; c++) begin rem[c] = 0; cur[c] = 0; end
    bus.enable_i = 1'b1;
    bus.pwm_i    = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    run(10);

    // Reset in the middle of a high phase, then a full pulse.
    add_pulse(0, 150, 100);
    run(60);
    do_reset(5);
    add_pulse(0, 180, 100);
    run_idle(2000);

    // Hysteresis sequence, saturation and threshold boundaries.
    add_pulse(0, 180, 300); add_pulse(0, 150, 300);
    add_pulse(0, 100, 300); add_pulse(0, 300, 250);
    add_pulse(1, 100, 300); add_pulse(1, 176, 300); add_pulse(1, 175, 300);
    add_pulse(1, 125, 300); add_pulse(1, 124, 300);
    add_pulse(2, 150, 350); add_pulse(2, 201, 300); add_pulse(2, 200, 300);
    add_pulse(3, 180, 320); add_pulse(3, 250, 300); add_pulse(3, 1, 1);
    run_idle(5000);

    // Four channels at once: 100/150/180/250.
    add_pulse(0, 100, 200); add_pulse(1, 150, 200);
    add_pulse(2, 180, 200); add_pulse(3, 250, 200);
    run_idle(2000);

    // Watchdog: silence past the period limit, then recover.
    run(MAXP + 100);
    add_pulse(0, 180, 100);
    run_idle(2000);

    // Enable dropped mid-pulse and restored before the fall.
    for (int c = 0; c < CH; c++) add_pulse(c, 150, 100);
    run(60);
    bus.enable_i = 1'b0;
    run(10);
    bus.enable_i = 1'b1;
    run_idle(2000);
    for (int c = 0; c < CH; c++) add_pulse(c, 120 + 30 * c, 100);
    run_idle(2000);

    // Randomised pulse trains with occasional long gaps and enable drops.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < CH; c++) begin
        for (int p = 0; p < 7; p++) begin
          int hi, lo;
          hi = int'($urandom_range(260, 1));
          lo = ($urandom_range(9, 0) == 0) ? int'($urandom_range(750, 550))
                                           : int'($urandom_range(200, 1));
          add_pulse(c, hi, lo);
        end
      end
      run(int'($urandom_range(400, 50)));
      bus.enable_i = 1'b0;
      run(int'($urandom_range(30, 1)));
      bus.enable_i = 1'b1;
      run_idle(20000);
    end

    run(20);
    for (int c = 0; c < CH; c++) chk("scoreboard_empty", c, sb[c].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
